poly_voice_mixer: RTL and testbench
===================================

POLY_VOICE_MIXER -- requirements
Module: poly_voice_mixer

Interface
REQ-001 The block SHALL have parameter NUM_VOICES, default 4, meaning number of polyphonic voices (legal range 2..16).
REQ-002 The block SHALL have parameter SAMPLE_WIDTH, default 16, meaning width of each signed two's-complement voice sample and of the mix output.
REQ-003 The block SHALL have parameter RATE_WIDTH, default 24, meaning width of the per-voice playback rate (cycles between samples).
REQ-004 The block SHALL have parameter NORM_MODE, default 0, meaning mix normalisation: 0 = fixed shift, 1 = shift by active-voice count.
REQ-005 clk_in  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-006 rst_in  input  1  synchronous, active-high reset.
REQ-007 note_valid_in  input  1  one-cycle strobe qualifying note_on_in, note_num_in and rate_in.
REQ-008 note_on_in  input  1  1 = note-on, 0 = note-off.
REQ-009 note_num_in  input  7  MIDI note number.
REQ-010 rate_in  input  RATE_WIDTH  playback rate for the note-on.
REQ-011 samples_in  input  NUM_VOICES*SAMPLE_WIDTH  current signed sample of each voice oscillator, voice 0 in the LSBs.
REQ-012 sample_tick_in  input  1  one-cycle strobe requesting a new mixed sample.
REQ-013 voice_on_out  output  NUM_VOICES  per-voice active flag.
REQ-014 voice_rate_out  output  NUM_VOICES*RATE_WIDTH  per-voice playback rate, voice 0 in the LSBs.
REQ-015 mix_out  output  SAMPLE_WIDTH  normalised signed mixed sample; holds its value between updates.
REQ-016 mix_valid_out  output  1  one-cycle pulse when mix_out updates.
REQ-017 busy_out  output  1  high while a mix is in progress.

Function
REQ-018 Each voice SHALL store active flag, 7-bit note, rate, and an age counter saturating at NUM_VOICES-1.
REQ-019 On a note-on, a voice already active with the same note SHALL be retriggered: rate replaced, age cleared, no other voice allocated.
REQ-020 Otherwise, a note-on SHALL allocate the lowest-index inactive voice.
REQ-021 If no voice is inactive, a note-on SHALL steal the voice with the highest age, ties resolved to the lowest index.
REQ-022 On any allocation or retrigger, the target voice age SHALL become 0 and every other active voice age SHALL increment (saturating).
REQ-023 A note-off SHALL clear the active flag of the voice holding that note and leave its rate unchanged; a note-off matching no voice SHALL be ignored.
REQ-024 Voice state changes SHALL be visible on voice_on_out/voice_rate_out the cycle after note_valid_in.
REQ-025 The mixer FSM SHALL have states IDLE, ACCUM, NORM and OUT.
REQ-026 IDLE -> ACCUM SHALL occur on sample_tick_in; the active mask and samples_in SHALL be snapshotted on that cycle.
REQ-027 ACCUM SHALL add one voice per cycle for NUM_VOICES cycles, with inactive voices contributing 0.
REQ-028 The accumulator SHALL be signed, SAMPLE_WIDTH+clog2(NUM_VOICES) bits wide, and SHALL never overflow.
REQ-029 In NORM, NORM_MODE=0 SHALL arithmetic-shift right by clog2(NUM_VOICES).
REQ-030 In NORM, NORM_MODE=1 SHALL arithmetic-shift right by ceil(log2(active count)), with 0 or 1 active giving no shift.
REQ-031 After the shift in NORM, the result SHALL be saturated to SAMPLE_WIDTH.
REQ-032 OUT SHALL register mix_out, pulse mix_valid_out, and return to IDLE.
REQ-033 mix_valid_out SHALL pulse exactly NUM_VOICES+2 cycles after the sample_tick_in cycle.
REQ-034 With zero active voices at the snapshot, the result SHALL be mix_out = 0.
REQ-035 sample_tick_in asserted while busy_out=1 SHALL be ignored.
REQ-036 busy_out SHALL be high from the cycle after the tick through the OUT cycle inclusive.
REQ-037 When note_valid_in and sample_tick_in coincide, both SHALL be processed, and the mix SHALL use the pre-event active mask.
REQ-038 Note events during ACCUM or NORM SHALL update voice state without affecting the mix in progress.

Reset
REQ-039 While rst_in=1, the block SHALL clear all active flags, notes, rates and ages, and hold voice_on_out=0, voice_rate_out=0, mix_out=0, mix_valid_out=0, busy_out=0 and FSM=IDLE.
REQ-040 Reset mid-mix SHALL abort the mix with no mix_valid_out pulse.
REQ-041 The first note-on after reset release SHALL allocate voice 0.

Verification
REQ-042 Allocation: 4 note-ons 60,62,64,65 -> voice_on_out=4'b1111 and voice_rate_out matches the rates per index; then note-off 62 -> voice_on_out=4'b1101.
REQ-043 Stealing: voices full with notes 60,62,64,65 in that order, then note-on 67 -> voice 0 gets note 67 and the new rate; repeat with note-on 69 -> voice 1.
REQ-044 Retrigger: note-on 60 twice with rates 1000 then 2000 -> one voice active, rate 2000.
REQ-045 Mix: NORM_MODE=0, voices 0 and 1 active with samples 0x4000 and 0x2000 -> mix_out=0x1800, with mix_valid_out 6 cycles after the tick; NORM_MODE=1 with the same stimulus -> mix_out=0x3000.
REQ-046 Boundary: all voices 0x7FFF, NORM_MODE=1 -> mix_out=0x7FFF; no voices active -> mix_out=0; second tick while busy -> exactly one mix_valid_out pulse.
REQ-047 Reset at ACCUM cycle 2 -> no mix_valid_out pulse, all outputs 0 next cycle.

Source files
------------

// File: rtl/poly_voice_mixer.sv
// Polyphonic voice allocator (retrigger / lowest-free / oldest-steal) feeding a
// sequential one-voice-per-cycle mixer with fixed or active-count normalisation.

module poly_voice_slot #(
    parameter int              RATE_WIDTH = 24,
    parameter int              AGE_W      = 2,
    parameter logic [AGE_W-1:0] AGE_MAX   = '1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  load,
    input  logic                  age_inc,
    input  logic                  off,
    input  logic [6:0]            new_note,
    input  logic [RATE_WIDTH-1:0] new_rate,
    output logic                  active,
    output logic [6:0]            note,
    output logic [RATE_WIDTH-1:0] rate,
    output logic [AGE_W-1:0]      age
);
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            active <= 1'b0;
            note   <= '0;
            rate   <= '0;
            age    <= '0;
        end else if (load) begin
            active <= 1'b1;
            note   <= new_note;
            rate   <= new_rate;
            age    <= '0;
        end else begin
            // note-off keeps the rate so the oscillator can release on it
            if (off) active <= 1'b0;
            if (age_inc && age != AGE_MAX) age <= age + AGE_W'(1);
        end
    end
endmodule

module poly_voice_mixer #(
    parameter int NUM_VOICES   = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int RATE_WIDTH   = 24,
    parameter int NORM_MODE    = 0
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             note_valid_in,
    input  logic                             note_on_in,
    input  logic [6:0]                       note_num_in,
    input  logic [RATE_WIDTH-1:0]            rate_in,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] samples_in,
    input  logic                             sample_tick_in,
    output logic [NUM_VOICES-1:0]            voice_on_out,
    output logic [NUM_VOICES*RATE_WIDTH-1:0] voice_rate_out,
    output logic [SAMPLE_WIDTH-1:0]          mix_out,
    output logic                             mix_valid_out,
    output logic                             busy_out
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_WIDTH + IDX_W;
    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    localparam int SH_W  = $clog2(IDX_W + 1);
    localparam logic [IDX_W-1:0]        AGE_MAX = IDX_W'(NUM_VOICES - 1);
    localparam logic [IDX_W-1:0]        LAST    = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, NORM, OUT} state_t;

    logic [NUM_VOICES-1:0]                 v_on, v_load, v_age_inc, v_off, v_match;
    logic [NUM_VOICES-1:0][6:0]            v_note;
    logic [NUM_VOICES-1:0][RATE_WIDTH-1:0] v_rate;
    logic [NUM_VOICES-1:0][IDX_W-1:0]      v_age;
    logic [IDX_W-1:0]                      tgt, best_age;
    logic                                  found, note_on_ev, note_off_ev;

    assign note_on_ev  = note_valid_in && note_on_in;
    assign note_off_ev = note_valid_in && !note_on_in;

    // target priority: retrigger match, then lowest free, then oldest (lowest index on tie)
    always_comb begin
        v_match   = '0;
        v_load    = '0;
        v_age_inc = '0;
        v_off     = '0;
        tgt       = '0;
        found     = 1'b0;
        best_age  = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            v_match[i] = v_on[i] && (v_note[i] == note_num_in);
        for (int i = 0; i < NUM_VOICES; i++)
            if (v_match[i] && !found) begin
                tgt   = IDX_W'(i);
                found = 1'b1;
            end
        for (int i = 0; i < NUM_VOICES; i++)
            if (!v_on[i] && !found) begin
                tgt   = IDX_W'(i);
                found = 1'b1;
            end
        if (!found) begin
            best_age = v_age[0];
            for (int i = 1; i < NUM_VOICES; i++)
                if (v_age[i] > best_age) begin
                    best_age = v_age[i];
                    tgt      = IDX_W'(i);
                end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            v_load[i]    = note_on_ev && (tgt == IDX_W'(i));
            v_age_inc[i] = note_on_ev && v_on[i] && (tgt != IDX_W'(i));
            v_off[i]     = note_off_ev && v_match[i];
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        poly_voice_slot #(
            .RATE_WIDTH (RATE_WIDTH),
            .AGE_W      (IDX_W),
            .AGE_MAX    (AGE_MAX)
        ) u_slot (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .load     (v_load[g]),
            .age_inc  (v_age_inc[g]),
            .off      (v_off[g]),
            .new_note (note_num_in),
            .new_rate (rate_in),
            .active   (v_on[g]),
            .note     (v_note[g]),
            .rate     (v_rate[g]),
            .age      (v_age[g])
        );
    end

    assign voice_on_out   = v_on;
    assign voice_rate_out = v_rate;

    state_t                                  state, state_nxt;
    logic [NUM_VOICES-1:0]                   mask_q;
    logic [NUM_VOICES-1:0][SAMPLE_WIDTH-1:0] samp_q;
    logic [IDX_W-1:0]                        idx;
    logic signed [ACC_W-1:0]                 acc, addend, shifted;
    logic [SAMPLE_WIDTH-1:0]                 cur_samp, sat_val;
    logic [CNT_W-1:0]                        act_cnt;
    logic [SH_W-1:0]                         sh;

    function automatic logic [SH_W-1:0] ceil_log2(input logic [CNT_W-1:0] n);
        ceil_log2 = '0;
        for (int k = 0; k < IDX_W; k++)
            if ((1 << k) < int'(n)) ceil_log2 = SH_W'(k + 1);
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_out  = (state != IDLE);
        case (state)
            IDLE:    if (sample_tick_in) state_nxt = ACCUM;
            ACCUM:   if (idx == LAST) state_nxt = NORM;
            NORM:    state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cur_samp = samp_q[idx];
        addend   = mask_q[idx] ? {{IDX_W{cur_samp[SAMPLE_WIDTH-1]}}, cur_samp} : '0;
        act_cnt  = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            act_cnt = act_cnt + CNT_W'(mask_q[i]);
        if (NORM_MODE == 0) sh = SH_W'(IDX_W);
        else                sh = ceil_log2(act_cnt);
        shifted = acc >>> sh;
        if (shifted > SAT_MAX)      sat_val = SAT_MAX[SAMPLE_WIDTH-1:0];
        else if (shifted < SAT_MIN) sat_val = SAT_MIN[SAMPLE_WIDTH-1:0];
        else                        sat_val = shifted[SAMPLE_WIDTH-1:0];
    end

    // the mask is taken from registered voice state, so a coincident note event is excluded
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mask_q        <= '0;
            samp_q        <= '0;
            idx           <= '0;
            acc           <= '0;
            mix_out       <= '0;
            mix_valid_out <= 1'b0;
        end else begin
            mix_valid_out <= 1'b0;
            case (state)
                IDLE: if (sample_tick_in) begin
                    mask_q <= v_on;
                    samp_q <= samples_in;
                    idx    <= '0;
                    acc    <= '0;
                end
                ACCUM: begin
                    acc <= acc + addend;
                    idx <= idx + IDX_W'(1);
                end
                NORM: begin
                    mix_out       <= sat_val;
                    mix_valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed + randomized bench for poly_voice_mixer; two instances (NORM_MODE 0 and 1)
// share stimulus and are checked against a queue-free array reference model.

module tb_poly_voice_mixer;
    logic        clk_in = 1'b0;
    logic        rst_in, note_valid_in, note_on_in, sample_tick_in;
    logic [6:0]  note_num_in;
    logic [23:0] rate_in;
    logic [63:0] samples_in;
    logic [3:0]  von0, von1;
    logic [95:0] vr0, vr1;
    logic [15:0] mix0, mix1;
    logic        mv0, mv1, busy0, busy1;

    int checks = 0;
    int failures = 0;

    bit          m_on[4];
    logic [6:0]  m_note[4];
    logic [23:0] m_rate[4];
    int          m_age[4];

    always #5 clk_in = ~clk_in;

    poly_voice_mixer #(.NUM_VOICES(4), .SAMPLE_WIDTH(16), .RATE_WIDTH(24), .NORM_MODE(0)) dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .note_valid_in(note_valid_in), .note_on_in(note_on_in),
        .note_num_in(note_num_in), .rate_in(rate_in), .samples_in(samples_in),
        .sample_tick_in(sample_tick_in), .voice_on_out(von0), .voice_rate_out(vr0),
        .mix_out(mix0), .mix_valid_out(mv0), .busy_out(busy0));

    poly_voice_mixer #(.NUM_VOICES(4), .SAMPLE_WIDTH(16), .RATE_WIDTH(24), .NORM_MODE(1)) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .note_valid_in(note_valid_in), .note_on_in(note_on_in),
        .note_num_in(note_num_in), .rate_in(rate_in), .samples_in(samples_in),
        .sample_tick_in(sample_tick_in), .voice_on_out(von1), .voice_rate_out(vr1),
        .mix_out(mix1), .mix_valid_out(mv1), .busy_out(busy1));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_mask();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = m_on[i];
        return m;
    endfunction

    function automatic logic [95:0] m_rates();
        logic [95:0] r;
        for (int i = 0; i < 4; i++) r[i*24 +: 24] = m_rate[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_on[i] = 0; m_note[i] = '0; m_rate[i] = '0; m_age[i] = 0;
        end
    endtask

    task automatic model_note(input bit on, input logic [6:0] num, input logic [23:0] rate);
        int t = -1;
        if (on) begin
            for (int i = 0; i < 4; i++) if (t < 0 && m_on[i] && m_note[i] == num) t = i;
            for (int i = 0; i < 4; i++) if (t < 0 && !m_on[i]) t = i;
            if (t < 0) begin
                t = 0;
                for (int i = 1; i < 4; i++) if (m_age[i] > m_age[t]) t = i;
            end
            for (int i = 0; i < 4; i++)
                if (i == t) m_age[i] = 0;
                else if (m_on[i] && m_age[i] < 3) m_age[i]++;
            m_on[t] = 1; m_note[t] = num; m_rate[t] = rate;
        end else begin
            for (int i = 0; i < 4; i++) if (m_on[i] && m_note[i] == num) m_on[i] = 0;
        end
    endtask

    function automatic logic [15:0] model_mix(input logic [3:0] mask, input logic [63:0] s, input int mode);
        int sum = 0, cnt = 0, sh = 0;
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            if (mask[i]) begin
                sum += int'($signed(s[i*16 +: 16]));
                cnt++;
            end
        if (mode == 0) sh = 2;
        else while ((1 << sh) < cnt) sh++;
        sum = sum >>> sh;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        r = sum;
        return r[15:0];
    endfunction

    task automatic chk_voices(input string tag);
        chk($sformatf("%s.on0", tag), von0, m_mask());
        chk($sformatf("%s.on1", tag), von1, m_mask());
        chk($sformatf("%s.rate0", tag), vr0, m_rates());
        chk($sformatf("%s.rate1", tag), vr1, m_rates());
    endtask

    task automatic drive_note(input bit on, input int num, input int rate);
        @(negedge clk_in);
        note_valid_in = 1; note_on_in = on; note_num_in = 7'(num); rate_in = 24'(rate);
        model_note(on, 7'(num), 24'(rate));
        @(negedge clk_in);
        note_valid_in = 0;
        chk_voices($sformatf("note%0d_%0d", on, num));
    endtask

    task automatic do_reset();
        @(negedge clk_in); rst_in = 1;
        @(negedge clk_in); rst_in = 0;
        model_reset();
    endtask

    // mode: 0 plain, 1 retick while busy, 2 note-on coincident with tick, 3 note-on mid-accumulate
    task automatic run_mix(input string tag, input logic [63:0] samp, input int mode);
        logic [3:0]  mask;
        logic [15:0] e0, e1;
        int p0 = 0, p1 = 0, pc = -1;
        logic b1 = 0, b6 = 0, b7 = 1;
        @(negedge clk_in);
        samples_in = samp; sample_tick_in = 1;
        mask = m_mask();
        e0 = model_mix(mask, samp, 0);
        e1 = model_mix(mask, samp, 1);
        if (mode == 2) begin
            note_valid_in = 1; note_on_in = 1; note_num_in = 7'd70; rate_in = 24'h00ABCD;
            model_note(1, 7'd70, 24'h00ABCD);
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                sample_tick_in = 0; note_valid_in = 0;
                samples_in = {$urandom, $urandom};
            end
            if (mode == 1 && k == 2) sample_tick_in = 1;
            if (mode == 1 && k == 3) sample_tick_in = 0;
            if (mode == 3 && k == 2) begin
                note_valid_in = 1; note_on_in = 1; note_num_in = 7'd71; rate_in = 24'h0F00D;
                model_note(1, 7'd71, 24'h0F00D);
            end
            if (mode == 3 && k == 3) note_valid_in = 0;
            if (mv0) begin p0++; pc = k; end
            if (mv1) p1++;
            if (k == 1) b1 = busy0;
            if (k == 6) b6 = busy0;
            if (k == 7) b7 = busy0;
        end
        chk($sformatf("%s.pulses0", tag), p0, 1);
        chk($sformatf("%s.pulses1", tag), p1, 1);
        chk($sformatf("%s.latency", tag), pc, 6);
        chk($sformatf("%s.mix0", tag), mix0, e0);
        chk($sformatf("%s.mix1", tag), mix1, e1);
        chk($sformatf("%s.busy_first", tag), b1, 1);
        chk($sformatf("%s.busy_out_state", tag), b6, 1);
        chk($sformatf("%s.busy_after", tag), b7, 0);
        chk_voices($sformatf("%s.voices", tag));
    endtask

    initial begin
        int pulses;
        rst_in = 1; note_valid_in = 0; note_on_in = 0; note_num_in = '0;
        rate_in = '0; samples_in = '0; sample_tick_in = 0;
        model_reset();
        repeat (3) @(negedge clk_in);
        chk("rst.on", {von0, von1}, 0);
        chk("rst.rate", {vr0, vr1}, 0);
        chk("rst.mix", {mix0, mix1}, 0);
        chk("rst.ctl", {mv0, mv1, busy0, busy1}, 0);
        rst_in = 0;

        // allocation order and note-off
        drive_note(1, 60, 1000);
        chk("first_alloc_v0", von0, 4'b0001);
        drive_note(1, 62, 1100);
        drive_note(1, 64, 1200);
        drive_note(1, 65, 1300);
        chk("alloc_full", von0, 4'b1111);
        chk("alloc_rate3", vr0[95:72], 24'd1300);
        drive_note(0, 62, 0);
        chk("off62", von0, 4'b1101);
        chk("off62_rate_kept", vr0[47:24], 24'd1100);
        drive_note(0, 99, 0);

        // two-voice mix, both normalisation modes
        do_reset();
        drive_note(1, 60, 500);
        drive_note(1, 62, 600);
        run_mix("mix2", {$urandom, 16'h2000, 16'h4000} & 64'h0000_0000_FFFF_FFFF | {$urandom, 32'h0}, 0);
        chk("mix2_mode0_abs", mix0, 16'h1800);
        chk("mix2_mode1_abs", mix1, 16'h3000);

        do_reset();
        run_mix("mix_none", {$urandom, $urandom}, 0);
        chk("mix_none_abs", mix1, 16'h0000);

        drive_note(1, 60, 10);
        drive_note(1, 62, 20);
        drive_note(1, 64, 30);
        drive_note(1, 65, 40);
        run_mix("mix_sat", 64'h7FFF_7FFF_7FFF_7FFF, 0);
        chk("mix_sat_abs", mix1, 16'h7FFF);
        run_mix("mix_neg", 64'h8000_8000_8000_8000, 0);

        // stealing oldest voice
        drive_note(1, 67, 777);
        chk("steal67_v0", vr0[23:0], 24'd777);
        drive_note(1, 69, 888);
        chk("steal69_v1", vr0[47:24], 24'd888);

        run_mix("retick", {$urandom, $urandom}, 1);
        run_mix("coincide", {$urandom, $urandom}, 2);
        run_mix("mid_note", {$urandom, $urandom}, 3);

        // retrigger
        do_reset();
        drive_note(1, 60, 1000);
        drive_note(1, 60, 2000);
        chk("retrig_on", von0, 4'b0001);
        chk("retrig_rate", vr0[23:0], 24'd2000);

        for (int it = 0; it < 60; it++) begin
            drive_note(($urandom % 3) != 0, 60 + int'($urandom % 8), int'($urandom % (1 << 24)));
            if (it % 6 == 5) run_mix($sformatf("rnd%0d", it), {$urandom, $urandom}, int'($urandom % 4));
        end

        // reset in the second accumulate cycle aborts the mix
        @(negedge clk_in); samples_in = {$urandom, $urandom}; sample_tick_in = 1;
        @(negedge clk_in); sample_tick_in = 0;
        @(negedge clk_in); rst_in = 1;
        @(negedge clk_in);
        chk("abort.on", {von0, von1}, 0);
        chk("abort.rate", {vr0, vr1}, 0);
        chk("abort.mix", {mix0, mix1}, 0);
        chk("abort.ctl", {mv0, mv1, busy0, busy1}, 0);
        rst_in = 0;
        model_reset();
        pulses = 0;
        repeat (8) begin
            @(negedge clk_in);
            if (mv0 || mv1) pulses++;
        end
        chk("abort.no_pulse", pulses, 0);
        drive_note(1, 50, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
